uart_rx: RTL and testbench

Asynchronous serial receiver for the UART datapath. It sits directly downstream of the baud-rate generator and consumes a 16x-oversampling tick. It recovers 8N1 or 8E1/8O1 frames from the serial line and presents each byte, with its error flags, on a one-entry valid/ready output register. Frame-level errors (framing, parity, overrun) are reported alongside the data.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled 8N1/8E1/8O1 UART receiver with a one-entry valid/ready output
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_in,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t     state, state_next;
    logic       sync_q1, rxs;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_q;
    logic       pen_q, podd_q, perr_q;
    logic       sample_pt, complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync_q1 <= rx_in;
            rxs     <= sync_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample_pt  = 1'b0;
        // Start bit is sampled mid-bit (8 ticks in); every later bit one full bit period after.
        if (sample_tick) begin
            case (state)
                S_START:                  sample_pt = (tick_cnt == 4'd7);
                S_DATA, S_PARITY, S_STOP: sample_pt = (tick_cnt == 4'd15);
                default:                  sample_pt = 1'b0;
            endcase
        end
        case (state)
            S_IDLE:   if (sample_tick && !rxs) state_next = S_START;
            S_START:  if (sample_pt) state_next = rxs ? S_IDLE : S_DATA;
            S_DATA:   if (sample_pt && bit_idx == 3'd7) state_next = pen_q ? S_PARITY : S_STOP;
            S_PARITY: if (sample_pt) state_next = S_STOP;
            S_STOP:   if (sample_pt) state_next = rxs ? S_IDLE : S_BREAK;
            S_BREAK:  if (rxs) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign complete = sample_pt && (state == S_STOP);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift_q  <= 8'h00;
            pen_q    <= 1'b0;
            podd_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (sample_tick) begin
                if (state == S_IDLE || sample_pt) tick_cnt <= 4'd0;
                else                              tick_cnt <= tick_cnt + 4'd1;
            end
            if (sample_pt) begin
                case (state)
                    S_START: begin
                        bit_idx <= 3'd0;
                        pen_q   <= parity_en;
                        podd_q  <= parity_odd;
                        perr_q  <= 1'b0;
                    end
                    S_DATA: begin
                        shift_q <= {rxs, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    S_PARITY: perr_q <= ((^shift_q) ^ rxs) != podd_q;
                    default: ;
                endcase
            end
        end
    end

    // A completing frame may load only if the slot is empty or being drained this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_q;
                    frame_err  <= ~rxs;
                    parity_err <= perr_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, directed corners, randomized frames
module tb_uart_rx;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    logic ready_man = 1'b1;
    logic ready_auto = 1'b0;
    logic auto_mode = 1'b0;
    assign rx_ready = auto_mode ? ready_auto : ready_man;

    int checks = 0;
    int errors = 0;

    uart_rx dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx_in(rx_in),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Tick generator plus a frame-length observer: counts ticks from busy rising to busy falling.
    int   tick_div = 0;
    int   tcount = 0;
    int   last_len = 0;
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        if (busy && !busy_q) tcount = 0;
        if (!busy && busy_q) last_len = tcount;
        busy_q = busy;
        tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        sample_tick = (tick_div == 0);
        if (sample_tick && busy) tcount++;
        ready_auto = auto_mode && busy && sample_tick && (tcount == 152);
    end

    int         vcnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (rx_valid) begin
            vcnt++;
            cap_data = rx_data;
            cap_fe   = frame_err;
            cap_pe   = parity_err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, o0, len;
        logic [7:0] d;
        logic pen, podd, pbit, stop, exp_pe;
        int ones;

        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1};
        vecs[3] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset frame_err", frame_err, 0);
        check("reset parity_err", parity_err, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        idle(20);

        for (int i = 0; i < 8; i++) begin
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            v0 = vcnt;
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
            check($sformatf("vec%0d count", i), vcnt - v0, 1);
            check($sformatf("vec%0d data", i), cap_data, vecs[i].exp_data);
            check($sformatf("vec%0d frame_err", i), cap_fe, vecs[i].exp_fe);
            check($sformatf("vec%0d parity_err", i), cap_pe, vecs[i].exp_pe);
            if (vecs[i].stop)
                check($sformatf("vec%0d length", i), last_len, vecs[i].pen ? 168 : 152);
            idle(20);
        end

        // Short low glitch: detected, rejected at the mid-start sample.
        parity_en = 1'b0;
        v0 = vcnt;
        rx_in = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx_in = 1'b1;
        check("glitch busy during start", busy, 1);
        repeat (20 * TICK_DIV) @(negedge clk);
        check("glitch busy after", busy, 0);
        check("glitch no delivery", vcnt - v0, 0);

        // Bad stop then a long low line: BREAK holds until the line returns high.
        v0 = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40 * TICK_DIV) @(negedge clk);
        check("break busy", busy, 1);
        check("break single delivery", vcnt - v0, 1);
        check("break data", cap_data, 8'h3C);
        check("break frame_err", cap_fe, 1);
        idle(4);
        check("break exit", busy, 0);
        v0 = vcnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check("after break count", vcnt - v0, 1);
        check("after break data", cap_data, 8'h81);
        check("after break frame_err", cap_fe, 0);
        idle(20);

        // Overrun: consumer stalled across two completions.
        ready_man = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(TICK_DIV);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("overrun held data", rx_data, 8'h11);
        check("overrun held valid", rx_valid, 1);
        check("overrun pulses", ovr_cnt - o0, 1);
        ready_man = 1'b1;
        @(negedge clk);
        check("overrun drain", rx_valid, 0);
        idle(20);

        // Acceptance on the exact completion edge: new byte loads, no overrun.
        ready_man = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(TICK_DIV);
        auto_mode = 1'b1;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        auto_mode = 1'b0;
        check("simul data", rx_data, 8'h22);
        check("simul valid", rx_valid, 1);
        check("simul no overrun", ovr_cnt - o0, 0);
        ready_man = 1'b1;
        idle(20);

        // Reset in the middle of data bit 4.
        v0 = vcnt;
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (84 * TICK_DIV) @(negedge clk);
                rst = 1'b1;
                #1;
                check("midrst busy", busy, 0);
                check("midrst rx_data", rx_data, 8'h00);
                check("midrst rx_valid", rx_valid, 0);
                check("midrst frame_err", frame_err, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        check("midrst no partial", vcnt - v0, 0);
        idle(20);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        check("post rst count", vcnt - v0, 1);
        check("post rst data", cap_data, 8'hF0);
        idle(20);

        // Randomized frames against the arithmetic model.
        for (int n = 0; n < 30; n++) begin
            d      = 8'($urandom_range(0, 255));
            pen    = 1'($urandom_range(0, 1));
            podd   = 1'($urandom_range(0, 1));
            pbit   = 1'($urandom_range(0, 1));
            stop   = ($urandom_range(0, 7) != 0);
            ones   = $countones({d, pbit});
            exp_pe = pen && ((ones % 2) != int'(podd));
            len    = pen ? 168 : 152;
            parity_en  = pen;
            parity_odd = podd;
            v0 = vcnt;
            send_frame(d, pen, pbit, stop);
            check($sformatf("rnd%0d count", n), vcnt - v0, 1);
            check($sformatf("rnd%0d data", n), cap_data, d);
            check($sformatf("rnd%0d frame_err", n), cap_fe, !stop);
            check($sformatf("rnd%0d parity_err", n), cap_pe, exp_pe);
            if (stop) check($sformatf("rnd%0d length", n), last_len, len);
            idle(stop ? $urandom_range(0, 3) * TICK_DIV : 16 + $urandom_range(0, 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
